// File: rtl/fp_result_collector.sv
// fp_result_collector: return path of the 1-to-4 FP operand dispatch.
// Results from the add (0), sub (1), mul (2) and div (3) units are parked in a
// one-entry holding register per channel. An arbiter then forwards them one at
// a time into a registered output stage, and each result is tagged with its
// source channel.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   inN_valid/inN_data/inN_ready  per-channel valid/ready result input, N = 0..3
//   out_valid/out_data/out_sel output result, source channel tag
//   out_ready                  downstream accepts the output
//
// Configuration macro FPRC_FIXED_PRIO_EN:
//   undefined : round-robin arbitration starting at rr_ptr
//   defined   : fixed priority, channel 0 highest; rr_ptr is not built
module fp_result_collector #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic             in1_valid,
    input  logic             in2_valid,
    input  logic             in3_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic [WIDTH-1:0] in1_data,
    input  logic [WIDTH-1:0] in2_data,
    input  logic [WIDTH-1:0] in3_data,
    output logic             in0_ready,
    output logic             in1_ready,
    output logic             in2_ready,
    output logic             in3_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    input  logic             out_ready
);

    logic [3:0]       in_valid;
    logic [WIDTH-1:0] in_data [4];
    logic [3:0]       in_ready;

    assign in_valid   = {in3_valid, in2_valid, in1_valid, in0_valid};
    assign in_data[0] = in0_data;
    assign in_data[1] = in1_data;
    assign in_data[2] = in2_data;
    assign in_data[3] = in3_data;
    assign in0_ready  = in_ready[0];
    assign in1_ready  = in_ready[1];
    assign in2_ready  = in_ready[2];
    assign in3_ready  = in_ready[3];

    logic [3:0]       hold_vld_q, hold_vld_d;
    logic [WIDTH-1:0] hold_data_q [4];
    logic [WIDTH-1:0] hold_data_d [4];
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       out_sel_q, out_sel_d;

    logic       load;
    logic [1:0] search_base;
    logic [1:0] idx;
    logic       grant_any;
    logic [1:0] grant_idx;
    logic [3:0] grant;

`ifdef FPRC_FIXED_PRIO_EN
    assign search_base = 2'd0;
`else
    logic [1:0] rr_ptr_q, rr_ptr_d;

    assign search_base = rr_ptr_q;
    assign rr_ptr_d    = grant_any ? grant_idx + 2'd1 : rr_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 2'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // The output register can take a new result when empty or being drained.
    assign load = !out_valid_q | out_ready;

    // First pending channel in search order search_base, +1, ... (mod 4).
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        idx       = 2'd0;
        grant     = 4'b0000;
        if (load) begin
            for (int k = 0; k < 4; k++) begin
                idx = search_base + 2'(k);
                if (!grant_any && hold_vld_q[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = idx;
                end
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Granted channel frees its slot this cycle, so it may refill at once;
    // this makes ready combinationally dependent on out_ready.
    assign in_ready = ~hold_vld_q | grant;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hold_vld_d[i]  = hold_vld_q[i];
            hold_data_d[i] = hold_data_q[i];
            if (grant[i]) begin
                hold_vld_d[i] = 1'b0;
            end
            // A same-cycle refill wins over the clear from the grant.
            if (in_valid[i] && in_ready[i]) begin
                hold_vld_d[i]  = 1'b1;
                hold_data_d[i] = in_data[i];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            out_valid_d = grant_any;
            if (grant_any) begin
                out_data_d = hold_data_q[grant_idx];
                out_sel_d  = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_q  <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                hold_data_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            for (int i = 0; i < 4; i++) begin
                hold_data_q[i] <= hold_data_d[i];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_fp_result_collector.sv
// Testbench for fp_result_collector: cycle vectors, hand-written corner
// sequences and a randomized soak checked by per-channel FIFO scoreboards.
module tb_fp_result_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in0_valid, in1_valid, in2_valid, in3_valid;
    logic [31:0] in0_data, in1_data, in2_data, in3_data;
    logic        in0_ready, in1_ready, in2_ready, in3_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    fp_result_collector #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in1_valid (in1_valid),
        .in2_valid (in2_valid),
        .in3_valid (in3_valid),
        .in0_data  (in0_data),
        .in1_data  (in1_data),
        .in2_data  (in2_data),
        .in3_data  (in3_data),
        .in0_ready (in0_ready),
        .in1_ready (in1_ready),
        .in2_ready (in2_ready),
        .in3_ready (in3_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    function automatic logic [3:0] rdy();
        return {in3_ready, in2_ready, in1_ready, in0_ready};
    endfunction

    task automatic drive(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d, input logic ordy);
        in0_valid = v[0]; in1_valid = v[1]; in2_valid = v[2]; in3_valid = v[3];
        in0_data  = a;    in1_data  = b;    in2_data  = c;    in3_data  = d;
        out_ready = ordy;
    endtask

    // Called at posedge+1: apply inputs, check ready before the edge,
    // then check the registered output just after the edge.
    task automatic step(input string name, input logic [3:0] v, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input logic [31:0] d,
                        input logic ordy, input logic [3:0] erdy, input logic eov,
                        input logic [31:0] eod, input logic [1:0] eos);
        drive(v, a, b, c, d, ordy);
        #1;
        check({name, "/ready"}, 64'(rdy()), 64'(erdy));
        @(posedge clk);
        #1;
        check({name, "/out_valid"}, 64'(out_valid), 64'(eov));
        if (eov) begin
            check({name, "/out_data"}, 64'(out_data), 64'(eod));
            check({name, "/out_sel"}, 64'(out_sel), 64'(eos));
        end
    endtask

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] d0, d1, d2, d3;
        logic        ordy;
        logic [3:0]  erdy;
        logic        eov;
        logic [31:0] eod;
        logic [1:0]  eos;
    } vec_t;

    vec_t vecs[13];

    // Scoreboard: per-channel FIFOs of accepted input words.
    logic [31:0] q0[$], q1[$], q2[$], q3[$];
    int n_in  = 0;
    int n_out = 0;

    function automatic void sb_push(input int ch, input logic [31:0] w);
        case (ch)
            0: q0.push_back(w);
            1: q1.push_back(w);
            2: q2.push_back(w);
            default: q3.push_back(w);
        endcase
    endfunction

    function automatic int sb_size(input int ch);
        case (ch)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [31:0] sb_pop(input int ch);
        case (ch)
            0: return q0.pop_front();
            1: return q1.pop_front();
            2: return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    // Sampled just before a rising edge: record what transfers at that edge.
    task automatic sb_sample();
        logic [3:0]  v;
        logic [3:0]  r;
        logic [31:0] exp_w;
        v = {in3_valid, in2_valid, in1_valid, in0_valid};
        r = rdy();
        if (out_valid && out_ready) begin
            n_out++;
            if (sb_size(int'(out_sel)) == 0) begin
                check("soak/spurious_output", 64'(out_sel), 64'hFF);
            end else begin
                exp_w = sb_pop(int'(out_sel));
                check("soak/order", 64'(out_data), 64'(exp_w));
            end
        end
        if (v[0] && r[0]) begin sb_push(0, in0_data); n_in++; end
        if (v[1] && r[1]) begin sb_push(1, in1_data); n_in++; end
        if (v[2] && r[2]) begin sb_push(2, in2_data); n_in++; end
        if (v[3] && r[3]) begin sb_push(3, in3_data); n_in++; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Cycle vectors from reset (rr_ptr = 0).
        vecs[0]  = '{4'hF, 32'hA, 32'hB, 32'hC, 32'hD, 1'b1, 4'hF, 1'b0, 32'h0, 2'd0};
        vecs[1]  = '{4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'h1, 1'b1, 32'hA, 2'd0};
        vecs[2]  = '{4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'h3, 1'b1, 32'hB, 2'd1};
        vecs[3]  = '{4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'h7, 1'b1, 32'hC, 2'd2};
        vecs[4]  = '{4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'hF, 1'b1, 32'hD, 2'd3};
        vecs[5]  = '{4'hF, 32'h1, 32'h2, 32'h3, 32'h4, 1'b1, 4'hF, 1'b0, 32'h0, 2'd0};
        vecs[6]  = '{4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'h1, 1'b1, 32'h1, 2'd0};
        vecs[7]  = '{4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 4'h1, 1'b1, 32'h1, 2'd0};
        vecs[8]  = '{4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'h3, 1'b1, 32'h2, 2'd1};
        vecs[9]  = '{4'h4, 32'h0, 32'h0, 32'h55, 32'h0, 1'b1, 4'h7, 1'b1, 32'h3, 2'd2};
`ifdef FPRC_FIXED_PRIO_EN
        vecs[10] = '{4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'h7, 1'b1, 32'h55, 2'd2};
        vecs[11] = '{4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'hF, 1'b1, 32'h4, 2'd3};
`else
        vecs[10] = '{4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'hB, 1'b1, 32'h4, 2'd3};
        vecs[11] = '{4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'hF, 1'b1, 32'h55, 2'd2};
`endif
        vecs[12] = '{4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'hF, 1'b0, 32'h0, 2'd0};

        rst_n = 1'b0;
        drive(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        #12;
        check("reset/out_valid", 64'(out_valid), 64'd0);
        check("reset/out_data", 64'(out_data), 64'd0);
        check("reset/out_sel", 64'(out_sel), 64'd0);
        check("reset/ready", 64'(rdy()), 64'hF);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            step($sformatf("vec%0d", i), vecs[i].vld, vecs[i].d0, vecs[i].d1, vecs[i].d2,
                 vecs[i].d3, vecs[i].ordy, vecs[i].erdy, vecs[i].eov, vecs[i].eod,
                 vecs[i].eos);
        end

        // Single channel streaming on ch1.
        step("stream0", 4'h2, 0, 32'h40000000, 0, 0, 1'b1, 4'hF, 1'b0, 0, 2'd0);
        step("stream1", 4'h2, 0, 32'h40400000, 0, 0, 1'b1, 4'hF, 1'b1, 32'h40000000, 2'd1);
        step("stream2", 4'h2, 0, 32'h40800000, 0, 0, 1'b1, 4'hF, 1'b1, 32'h40400000, 2'd1);
        step("stream3", 4'h0, 0, 0, 0, 0, 1'b1, 4'hF, 1'b1, 32'h40800000, 2'd1);
        step("stream4", 4'h0, 0, 0, 0, 0, 1'b1, 4'hF, 1'b0, 0, 2'd0);

        // Same-cycle refill on ch2.
        step("refill0", 4'h4, 0, 0, 32'h77, 0, 1'b1, 4'hF, 1'b0, 0, 2'd0);
        step("refill1", 4'h4, 0, 0, 32'h88, 0, 1'b1, 4'hF, 1'b1, 32'h77, 2'd2);
        step("refill2", 4'h0, 0, 0, 0, 0, 1'b1, 4'hF, 1'b1, 32'h88, 2'd2);
        step("refill3", 4'h0, 0, 0, 0, 0, 1'b1, 4'hF, 1'b0, 0, 2'd0);

        // Backpressure: ch3 sends two results while out_ready is low.
        step("bp0", 4'h8, 0, 0, 0, 32'h11, 1'b0, 4'hF, 1'b0, 0, 2'd0);
        step("bp1", 4'h8, 0, 0, 0, 32'h22, 1'b0, 4'hF, 1'b1, 32'h11, 2'd3);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("bp_stall%0d", i), 4'h0, 0, 0, 0, 0, 1'b0, 4'h7, 1'b1, 32'h11,
                 2'd3);
        end
        step("bp_rel0", 4'h0, 0, 0, 0, 0, 1'b1, 4'hF, 1'b1, 32'h22, 2'd3);
        step("bp_rel1", 4'h0, 0, 0, 0, 0, 1'b1, 4'hF, 1'b0, 0, 2'd0);

`ifdef FPRC_FIXED_PRIO_EN
        // Continuous ch0 traffic holds off ch1..3.
        step("fp0", 4'hF, 32'h1, 32'h2, 32'h3, 32'h4, 1'b1, 4'hF, 1'b0, 0, 2'd0);
        step("fp1", 4'h1, 32'h5, 0, 0, 0, 1'b1, 4'h1, 1'b1, 32'h1, 2'd0);
        step("fp2", 4'h1, 32'h6, 0, 0, 0, 1'b1, 4'h1, 1'b1, 32'h5, 2'd0);
        step("fp3", 4'h0, 0, 0, 0, 0, 1'b1, 4'h1, 1'b1, 32'h6, 2'd0);
        step("fp4", 4'h0, 0, 0, 0, 0, 1'b1, 4'h3, 1'b1, 32'h2, 2'd1);
        step("fp5", 4'h0, 0, 0, 0, 0, 1'b1, 4'h7, 1'b1, 32'h3, 2'd2);
        step("fp6", 4'h0, 0, 0, 0, 0, 1'b1, 4'hF, 1'b1, 32'h4, 2'd3);
        step("fp7", 4'h0, 0, 0, 0, 0, 1'b1, 4'hF, 1'b0, 0, 2'd0);
`endif

        // Random soak against the scoreboard.
        for (int cyc = 0; cyc < 600; cyc++) begin
            drive(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom,
                  ($urandom_range(0, 9) < 7));
            #3;
            sb_sample();
            @(posedge clk);
            #1;
        end
        drive(4'h0, 0, 0, 0, 0, 1'b1);
        for (int cyc = 0; cyc < 30; cyc++) begin
            #3;
            if (!out_valid && sb_size(0) + sb_size(1) + sb_size(2) + sb_size(3) == 0) break;
            sb_sample();
            @(posedge clk);
            #1;
        end
        check("soak/drained_out_valid", 64'(out_valid), 64'd0);
        check("soak/leftover", 64'(sb_size(0) + sb_size(1) + sb_size(2) + sb_size(3)), 64'd0);
        check("soak/count", 64'(n_out), 64'(n_in));

        // Reset in the middle of traffic.
        drive(4'hF, 32'h101, 32'h202, 32'h303, 32'h404, 1'b0);
        @(posedge clk);
        #1;
        drive(4'hF, 32'h505, 32'h606, 32'h707, 32'h808, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset/out_valid", 64'(out_valid), 64'd0);
        check("midreset/out_data", 64'(out_data), 64'd0);
        check("midreset/out_sel", 64'(out_sel), 64'd0);
        check("midreset/ready", 64'(rdy()), 64'hF);
        drive(4'h0, 0, 0, 0, 0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("postrst0", 4'h4, 0, 0, 32'h3F800000, 0, 1'b1, 4'hF, 1'b0, 0, 2'd0);
        step("postrst1", 4'h0, 0, 0, 0, 0, 1'b1, 4'hF, 1'b1, 32'h3F800000, 2'd2);
        step("postrst2", 4'h0, 0, 0, 0, 0, 1'b1, 4'hF, 1'b0, 0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_result_collector.md
# fp_result_collector

Gathers floating-point results from the four operation units (add, sub, mul, div) and delivers them one at a time onto a single 32-bit result bus. It is the return path of the 1-to-4 operand dispatch, and tags each result with the 2-bit operation select it came from. Each channel has a one-entry holding register and a valid/ready handshake. A registered output stage and a round-robin arbiter give up to one result per cycle.

## Interface
- `WIDTH`, default 32: result data width; IEEE-754 single.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in0_valid` … `in3_valid` input 1 each: result valid from add (0), sub (1), mul (2), div (3).
- `in0_data` … `in3_data` input `WIDTH` each: result word per channel.
- `in0_ready` … `in3_ready` output 1 each: channel may present a result this cycle.
- `out_valid` output 1: `out_data`/`out_sel` hold a result.
- `out_data` output `WIDTH`: collected result.
- `out_sel` output 2: source channel; same encoding as the dispatch select.
- `out_ready` input 1: downstream accepts.

## Operation
- Per channel i, a holding register `hold_v[i]` / `hold_d[i]`.
- Input transfer on channel i: `ini_valid & ini_ready` at a rising edge loads `hold_d[i]` and sets `hold_v[i]`.
- `ini_ready = !hold_v[i] | grant[i]`. The combinational path from `out_ready` through grant to `ini_ready` is intentional.
- Output stage load enable: `load = !out_valid | out_ready`.
- Arbitration runs only when `load` is 1. Candidates are channels with `hold_v` set. The search order is `rr_ptr`, `rr_ptr+1`, … mod 4, and the first hit is granted. At most one grant per cycle.
- On a grant to channel g:
  - `out_data <= hold_d[g]`, `out_sel <= g`, `out_valid <= 1`.
  - `rr_ptr <= (g+1) mod 4`.
  - `hold_v[g]` clears, unless channel g transfers a new result in the same cycle. In that case `hold_v[g]` stays 1 with the new data.
- If `load` is 1 and no channel is pending, `out_valid <= 0`.
- `out_valid`, `out_data` and `out_sel` remain stable while `out_valid & !out_ready`.
- No data modification. The sign handling done at dispatch is already reflected in the unit results.
- Reset values (asynchronous, on `rst_n` low):
  - `hold_v` = 0, `hold_d` = 0.
  - `out_valid` = 0, `out_data` = 0, `out_sel` = 0.
  - `rr_ptr` = 0.
  - Therefore all `ini_ready` = 1 during and after reset.
- Reset mid-operation discards all held and output results. There is no partial state after release.

## Timing
- Minimum latency: input transfer at edge N; `out_valid` is asserted after edge N+1 (two edges).
- Throughput: one output per cycle aggregate; one per cycle per channel when it is the only active channel.
- Four simultaneous inputs with `out_ready` held 1:
  - Outputs on four consecutive cycles, in order `rr_ptr`, `rr_ptr+1`, ….
  - Each channel's `ready` reasserts the cycle it is granted.
- Output stall (`out_ready` = 0, `out_valid` = 1):
  - No grants.
  - Up to four results stay parked in the holding registers.
  - Channels with `hold_v` set drop `ready`.
- `rr_ptr` wraps from 3 to 0.

## Configuration
- `FPRC_FIXED_PRIO_EN` undefined: round-robin as above.
- `FPRC_FIXED_PRIO_EN` defined:
  - Fixed priority; channel 0 is highest and channel 3 lowest.
  - `rr_ptr` is not implemented.
  - All other behaviour is unchanged. Starvation of lower channels under continuous channel-0 traffic is accepted.

## Test plan
- **Reset:** assert `rst_n`=0 mid-traffic.
  - All outputs read 0 immediately.
  - `in0_ready`…`in3_ready` read 1.
  - The first post-reset single input 0x3F800000 on ch2 emerges with `out_sel`=2 after two edges.
- **Single channel streaming:** ch1 sends 0x40000000, 0x40400000, 0x40800000 on consecutive cycles with `out_ready`=1.
  - Outputs appear in order on consecutive cycles, `out_sel`=1.
  - `in1_ready` never deasserts.
- **Simultaneous arrival:** all four channels valid in one cycle with data 0xA, 0xB, 0xC, 0xD after reset.
  - Outputs are 0xA, 0xB, 0xC, 0xD with `out_sel` 0,1,2,3.
  - A second burst starts at ch0 again, since `rr_ptr` has wrapped to 0.
  - With `FPRC_FIXED_PRIO_EN`, ch0 re-sent each cycle blocks ch1–3 until it stops.
- **Backpressure:** hold `out_ready`=0 for 5 cycles while ch3 sends two results.
  - `out_data` is stable.
  - `in3_ready` drops after the first result is held.
  - On release, the remaining results drain, with no loss or duplication.
- **Same-cycle refill:** ch2 pending and granted while `in2_valid`=1 with a new word.
  - The new word is captured.
  - `hold_v[2]` stays 1.
  - It is output the next cycle.
- **Random soak:** randomized valids on all channels and random `out_ready`.
  - A scoreboard checks per-channel order preservation and the exact result count.
  - No output occurs without a matching input.
